lcd_video_source: RTL and testbench

Pixel-clock-domain video source that generates panel timing (HSync/VSync/DataEnable), a selectable test pattern and the packed 21-bit LVDS word consumed by the 7:1 serializer (`n_x_serdes_7_to_1_diff_ddr`, 3 data lanes). It sits directly upstream of the serializer and replaces the inline sync/pattern logic in the top level. It also provides pixel coordinates and a frame-start strobe for later frame-buffer readout.

---
 rtl/lcd_video_pkg.sv | 46 ++++
 rtl/lcd_timing_gen.sv | 123 ++++++++++++
 rtl/lcd_video_source.sv | 147 ++++++++++++++
 tb/tb_lcd_video_source.sv | 327 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_video_pkg.sv
// lcd_video_pkg
// Shared definitions for the pixel-clock video source:
//   - default panel timing (1366x768 active, 174/12 blanking)
//   - test-pattern selector encoding
//   - timing region decode used by the counter block
//   - LVDS 21-bit packing for the 3-lane 7:1 serializer, and its idle word
package lcd_video_pkg;

  localparam int unsigned H_ACTIVE_DEF = 1366;
  localparam int unsigned V_ACTIVE_DEF = 768;
  localparam int unsigned H_BLANK_DEF  = 174;
  localparam int unsigned V_BLANK_DEF  = 12;

  typedef enum logic [1:0] {
    PAT_BAR   = 2'd0,
    PAT_GRAD  = 2'd1,
    PAT_CBAR  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_t;

  // Timing region decoded from the counters; the counters are the only state.
  typedef enum logic [1:0] {
    ST_ACTIVE,
    ST_H_BLANK,
    ST_V_BLANK
  } region_t;

  // HS=1, VS=1, DE=0, RGB=0
  localparam logic [20:0] IDLE_WORD = 21'h018000;

  // Lane word layout, MSB first:
  //   [20:14] B2 B3 B4 B5 HS VS DE
  //   [13:7]  G1 G2 G3 G4 G5 B0 B1
  //   [6:0]   R0 R1 R2 R3 R4 R5 G0
  function automatic logic [20:0] pack_lvds(input logic [5:0] r,
                                            input logic [5:0] g,
                                            input logic [5:0] b,
                                            input logic       hs,
                                            input logic       vs,
                                            input logic       de);
    return {b[2], b[3], b[4], b[5], hs, vs, de,
            g[1], g[2], g[3], g[4], g[5], b[0], b[1],
            r[0], r[1], r[2], r[3], r[4], r[5], g[0]};
  endfunction

endpackage

// File: rtl/lcd_timing_gen.sv
// lcd_timing_gen
// Horizontal/vertical counters (pipeline stage 0) plus registered sync,
// data-enable, coordinates and frame-start strobe (stage 1).
// Ports:
//   clk, rst         pixel clock, asynchronous active-low reset
//   enable           run timing; low forces counters to 0 and stage 1 idle
//   h_cnt            stage-0 horizontal counter
//   v_low            stage-0 vertical counter, low 6 bits
//   at_origin        stage-0 counters at (0,0)
//   active           stage-0 counters inside the active area
//   hsync/vsync/de   stage-1 syncs and data enable
//   frame_start      stage-1 strobe for pixel (0,0)
//   pixel_x/pixel_y  stage-1 coordinates
//   frame_count      completed frames, wraps 255->0, holds while disabled
// H_ACTIVE+H_BLANK and V_ACTIVE+V_BLANK must not exceed 2047.
module lcd_timing_gen
  import lcd_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned H_BLANK  = H_BLANK_DEF,
  parameter int unsigned V_BLANK  = V_BLANK_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [10:0] h_cnt,
  output logic [5:0]  v_low,
  output logic        at_origin,
  output logic        active,
  output logic        hsync,
  output logic        vsync,
  output logic        de,
  output logic        frame_start,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic [7:0]  frame_count
);

  localparam logic [10:0] H_ACT  = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT  = 11'(V_ACTIVE);
  localparam logic [10:0] H_LAST = 11'(H_ACTIVE + H_BLANK - 1);
  localparam logic [10:0] V_LAST = 11'(V_ACTIVE + V_BLANK - 1);

  logic [10:0] v_cnt;
  logic [10:0] h_next;
  logic [10:0] v_next;
  logic [7:0]  fc_next;
  region_t     region;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      h_cnt       <= '0;
      v_cnt       <= '0;
      frame_count <= '0;
    end else begin
      h_cnt       <= h_next;
      v_cnt       <= v_next;
      frame_count <= fc_next;
    end
  end

  // A frame only counts when the counters leave the last pixel; dropping
  // enable resets the position without touching frame_count.
  always_comb begin
    h_next  = h_cnt;
    v_next  = v_cnt;
    fc_next = frame_count;
    if (!enable) begin
      h_next = '0;
      v_next = '0;
    end else if (h_cnt == H_LAST) begin
      h_next = '0;
      if (v_cnt == V_LAST) begin
        v_next  = '0;
        fc_next = frame_count + 8'd1;
      end else begin
        v_next = v_cnt + 11'd1;
      end
    end else begin
      h_next = h_cnt + 11'd1;
    end
  end

  always_comb begin
    region = ST_ACTIVE;
    if (v_cnt >= V_ACT) begin
      region = ST_V_BLANK;
    end else if (h_cnt >= H_ACT) begin
      region = ST_H_BLANK;
    end
  end

  assign active    = (region == ST_ACTIVE);
  assign at_origin = (h_cnt == '0) && (v_cnt == '0);
  assign v_low     = v_cnt[5:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else if (!enable) begin
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      de          <= 1'b0;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      hsync       <= (h_cnt < H_ACT);
      vsync       <= (v_cnt < V_ACT);
      de          <= active;
      frame_start <= at_origin;
      pixel_x     <= h_cnt;
      pixel_y     <= v_cnt;
    end
  end

endmodule

// File: rtl/lcd_video_source.sv
// lcd_video_source
// Pixel-clock video source feeding the 3-lane 7:1 LVDS serializer.
// Stage 0 counters, stage 1 syncs/coordinates/RGB, stage 2 packed word.
// Ports:
//   clk          pixel clock
//   rst          asynchronous active-low reset (released synchronously)
//   enable       run timing; low drains the output to the idle word
//   pattern_sel  0 bar, 1 gradient, 2 colour bars, 3 scrolling checker
//   video_data   packed 21-bit word for the serializer
//   frame_start  one-cycle pulse with pixel (0,0) on video_data
//   pixel_x/y    coordinates of the pixel on video_data
//   frame_count  completed frames, wrapping
// Pixel (0,0) reaches video_data on the second enabled clock edge.
module lcd_video_source
  import lcd_video_pkg::*;
#(
  parameter int unsigned H_ACTIVE  = H_ACTIVE_DEF,
  parameter int unsigned V_ACTIVE  = V_ACTIVE_DEF,
  parameter int unsigned H_BLANK   = H_BLANK_DEF,
  parameter int unsigned V_BLANK   = V_BLANK_DEF,
  parameter int unsigned BAR_LIMIT = 100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  pattern_sel,
  output logic [20:0] video_data,
  output logic        frame_start,
  output logic [10:0] pixel_x,
  output logic [10:0] pixel_y,
  output logic [7:0]  frame_count
);

  localparam logic [10:0] BAR_LAST = 11'(BAR_LIMIT);

  logic [10:0] h_cnt;
  logic [5:0]  v_low;
  logic        at_origin;
  logic        active;
  logic        s1_hsync;
  logic        s1_vsync;
  logic        s1_de;
  logic        s1_frame_start;
  logic [10:0] s1_x;
  logic [10:0] s1_y;
  logic [5:0]  s1_r;
  logic [5:0]  s1_g;
  logic [5:0]  s1_b;

  pattern_t    pat_q;
  pattern_t    pat_cur;
  logic [5:0]  r_d;
  logic [5:0]  g_d;
  logic [5:0]  b_d;
  logic [10:0] check_x;
  logic [2:0]  bar_idx;

  lcd_timing_gen #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .H_BLANK  (H_BLANK),
    .V_BLANK  (V_BLANK)
  ) u_timing (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .h_cnt       (h_cnt),
    .v_low       (v_low),
    .at_origin   (at_origin),
    .active      (active),
    .hsync       (s1_hsync),
    .vsync       (s1_vsync),
    .de          (s1_de),
    .frame_start (s1_frame_start),
    .pixel_x     (s1_x),
    .pixel_y     (s1_y),
    .frame_count (frame_count)
  );

  // At (0,0) the live selector is used directly so pixel (0,0) already
  // shows the pattern that the rest of the frame will hold.
  always_comb begin
    pat_cur = at_origin ? pattern_t'(pattern_sel) : pat_q;
    r_d     = '0;
    g_d     = '0;
    b_d     = '0;
    check_x = h_cnt + {3'b000, frame_count};
    bar_idx = h_cnt[10:8];
    if (enable && active) begin
      case (pat_cur)
        PAT_BAR: begin
          if (h_cnt <= BAR_LAST) begin
            b_d = '1;
          end
        end
        PAT_GRAD: begin
          r_d = h_cnt[5:0];
          g_d = v_low;
        end
        PAT_CBAR: begin
          r_d = {6{bar_idx[0]}};
          g_d = {6{bar_idx[1]}};
          b_d = {6{bar_idx[2]}};
        end
        PAT_CHECK: begin
          if (check_x[4] ^ v_low[4]) begin
            r_d = '1;
            g_d = '1;
            b_d = '1;
          end
        end
        default: begin
          r_d = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q <= PAT_BAR;
      s1_r  <= '0;
      s1_g  <= '0;
      s1_b  <= '0;
    end else begin
      pat_q <= pat_cur;
      s1_r  <= r_d;
      s1_g  <= g_d;
      s1_b  <= b_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      video_data  <= IDLE_WORD;
      frame_start <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
    end else begin
      video_data  <= pack_lvds(s1_r, s1_g, s1_b, s1_hsync, s1_vsync, s1_de);
      frame_start <= s1_frame_start;
      pixel_x     <= s1_x;
      pixel_y     <= s1_y;
    end
  end

endmodule

// File: tb/tb_lcd_video_source.sv
// tb_lcd_video_source
// Directed bench. Main DUT: full line width (1366+174) with a short frame
// (4 active + 2 blank lines, 9240 pixels) so several frames fit the run.
// Second DUT: tiny 8+2 x 4+1 geometry (50 pixels/frame) for the 256-frame
// frame_count wrap. Expected words are hand-computed LVDS packings.
module tb_lcd_video_source;

  localparam int HT = 1540;
  localparam int FT = HT * 6;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable;
  logic [1:0]  pattern_sel;
  logic [20:0] video_data;
  logic        frame_start;
  logic [10:0] pixel_x;
  logic [10:0] pixel_y;
  logic [7:0]  frame_count;

  logic        rst_s = 1'b1;
  logic        en_s;
  logic [20:0] video_data_s;
  logic        frame_start_s;
  logic [10:0] pixel_x_s;
  logic [10:0] pixel_y_s;
  logic [7:0]  frame_count_s;

  int checks   = 0;
  int failures = 0;
  int shown;
  logic done_s = 1'b0;

  always #5 clk = ~clk;

  lcd_video_source #(
    .H_ACTIVE  (1366),
    .V_ACTIVE  (4),
    .H_BLANK   (174),
    .V_BLANK   (2),
    .BAR_LIMIT (100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pattern_sel (pattern_sel),
    .video_data  (video_data),
    .frame_start (frame_start),
    .pixel_x     (pixel_x),
    .pixel_y     (pixel_y),
    .frame_count (frame_count)
  );

  lcd_video_source #(
    .H_ACTIVE  (8),
    .V_ACTIVE  (4),
    .H_BLANK   (2),
    .V_BLANK   (1),
    .BAR_LIMIT (100)
  ) dut_small (
    .clk         (clk),
    .rst         (rst_s),
    .enable      (en_s),
    .pattern_sel (2'd0),
    .video_data  (video_data_s),
    .frame_start (frame_start_s),
    .pixel_x     (pixel_x_s),
    .pixel_y     (pixel_y_s),
    .frame_count (frame_count_s)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock; afterwards video_data carries linear pixel index 'shown'.
  task automatic step();
    @(posedge clk);
    #1;
    shown++;
  endtask

  task automatic goto_pix(input int f, input int x, input int y);
    int target;
    target = f * FT + y * HT + x;
    if (target < shown) begin
      check_eq("goto_order", shown, target);
    end else begin
      repeat (target - shown) step();
    end
  endtask

  // 256-frame wrap on the small DUT, 50 enabled edges per frame.
  initial begin
    wait (en_s === 1'b1);
    repeat (50) @(posedge clk);
    #1;
    check_eq("wrap_fc_1", frame_count_s, 1);
    repeat (12700) @(posedge clk);
    #1;
    check_eq("wrap_fc_255", frame_count_s, 255);
    repeat (49) @(posedge clk);
    #1;
    check_eq("wrap_fc_255_hold", frame_count_s, 255);
    @(posedge clk);
    #1;
    check_eq("wrap_fc_0", frame_count_s, 0);
    done_s = 1'b1;
  end

  initial begin
    int prev_de;
    int rises;
    int last_rise;
    int per_min;
    int per_max;
    int run;
    int run_min;
    int run_max;
    int de_total;
    int vs_low;
    int hs_low;
    int guard;

    enable      = 1'b0;
    en_s        = 1'b0;
    pattern_sel = 2'd0;
    shown       = 0;

    #2;
    rst   = 1'b0;
    rst_s = 1'b0;
    #1;
    check_eq("rst_video", video_data, 21'h018000);
    check_eq("rst_fs", frame_start, 0);
    check_eq("rst_px", pixel_x, 0);
    check_eq("rst_py", pixel_y, 0);
    check_eq("rst_fc", frame_count, 0);

    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b1;
    rst_s = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("idle_video", video_data, 21'h018000);
    check_eq("idle_fc", frame_count, 0);

    enable = 1'b1;
    en_s   = 1'b1;
    shown  = -2;
    step();
    check_eq("e1_fs", frame_start, 0);
    check_eq("e1_video", video_data, 21'h018000);
    step();
    check_eq("e2_fs", frame_start, 1);
    check_eq("e2_video", video_data, 21'h1FC180);
    check_eq("e2_px", pixel_x, 0);
    check_eq("e2_py", pixel_y, 0);

    // Pattern 0, frame 0
    goto_pix(0, 100, 0);
    check_eq("bar_x100", video_data, 21'h1FC180);
    check_eq("bar_x100_fs", frame_start, 0);
    goto_pix(0, 101, 0);
    check_eq("bar_x101", video_data, 21'h01C000);
    goto_pix(0, 1366, 0);
    check_eq("hblank_x1366", video_data, 21'h008000);
    goto_pix(0, 1539, 0);
    check_eq("hblank_last", video_data, 21'h008000);
    check_eq("hblank_last_px", pixel_x, 1539);
    goto_pix(0, 0, 1);
    check_eq("line1_x0", video_data, 21'h1FC180);
    check_eq("line1_py", pixel_y, 1);

    // Mid-frame selector change must wait for the next frame
    goto_pix(0, 10, 2);
    pattern_sel = 2'd3;
    goto_pix(0, 16, 3);
    check_eq("no_early_switch", video_data, 21'h1FC180);
    goto_pix(0, 100, 4);
    check_eq("vblank_word", video_data, 21'h010000);
    goto_pix(0, 1400, 5);
    check_eq("vhblank_word", video_data, 21'h000000);

    // Frame 1: checker, frame_count=1 shifts x by one
    goto_pix(1, 0, 0);
    check_eq("f1_fs", frame_start, 1);
    check_eq("f1_fc", frame_count, 1);
    check_eq("chk_x0", video_data, 21'h01C000);
    goto_pix(1, 14, 0);
    check_eq("chk_x14", video_data, 21'h01C000);
    goto_pix(1, 15, 0);
    check_eq("chk_x15", video_data, 21'h1FFFFF);
    goto_pix(1, 16, 0);
    check_eq("chk_x16", video_data, 21'h1FFFFF);
    pattern_sel = 2'd2;

    // Frame 2: colour bars
    goto_pix(2, 0, 0);
    check_eq("cbar_x0", video_data, 21'h01C000);
    goto_pix(2, 255, 0);
    check_eq("cbar_x255", video_data, 21'h01C000);
    goto_pix(2, 256, 0);
    check_eq("cbar_red", video_data, 21'h01C07E);
    goto_pix(2, 512, 0);
    check_eq("cbar_green", video_data, 21'h01FE01);
    goto_pix(2, 1280, 0);
    check_eq("cbar_magenta", video_data, 21'h1FC1FE);
    goto_pix(2, 1365, 0);
    check_eq("cbar_x1365", video_data, 21'h1FC1FE);
    goto_pix(2, 1366, 0);
    check_eq("cbar_x1366", video_data, 21'h008000);
    pattern_sel = 2'd1;

    // frame_count steps when the counters (2 ahead) leave the last pixel
    goto_pix(2, 1537, 5);
    check_eq("fc_before_wrap", frame_count, 2);
    goto_pix(2, 1538, 5);
    check_eq("fc_three", frame_count, 3);

    // Timing measurement over all of frame 3
    goto_pix(2, 1539, 5);
    prev_de   = int'(video_data[14]);
    rises     = 0;
    last_rise = -1;
    per_min   = 1 << 30;
    per_max   = 0;
    run       = 0;
    run_min   = 1 << 30;
    run_max   = 0;
    de_total  = 0;
    vs_low    = 0;
    hs_low    = 0;
    repeat (FT) begin
      step();
      if (video_data[14]) begin
        de_total++;
        run++;
        if (prev_de == 0) begin
          rises++;
          if (last_rise >= 0) begin
            if (shown - last_rise < per_min) per_min = shown - last_rise;
            if (shown - last_rise > per_max) per_max = shown - last_rise;
          end
          last_rise = shown;
        end
      end else if (prev_de == 1) begin
        if (run < run_min) run_min = run;
        if (run > run_max) run_max = run;
        run = 0;
      end
      if (!video_data[15]) vs_low++;
      if (!video_data[16]) hs_low++;
      prev_de = int'(video_data[14]);
    end
    check_eq("de_rises", rises, 4);
    check_eq("de_period_min", per_min, 1540);
    check_eq("de_period_max", per_max, 1540);
    check_eq("de_len_min", run_min, 1366);
    check_eq("de_len_max", run_max, 1366);
    check_eq("de_total", de_total, 4 * 1366);
    check_eq("vs_low", vs_low, 2 * 1540);
    check_eq("hs_low", hs_low, 6 * 174);

    // Frame 4: gradient
    goto_pix(4, 5, 0);
    check_eq("grad_x5", video_data, 21'h01C050);
    goto_pix(4, 64, 0);
    check_eq("grad_x64", video_data, 21'h01C000);
    goto_pix(4, 70, 0);
    check_eq("grad_x70", video_data, 21'h01C030);
    check_eq("grad_px70", pixel_x, 70);
    goto_pix(4, 1, 3);
    check_eq("grad_x1_y3", video_data, 21'h01E041);
    check_eq("grad_py3", pixel_y, 3);

    // Drop enable while the counters sit at h=500, v=3
    goto_pix(4, 498, 3);
    enable = 1'b0;
    step();
    check_eq("drop_d1_fc", frame_count, 4);
    step();
    check_eq("drop_d2_video", video_data, 21'h018000);
    check_eq("drop_d2_fs", frame_start, 0);
    repeat (20) step();
    check_eq("drop_hold_video", video_data, 21'h018000);
    check_eq("drop_hold_fc", frame_count, 4);

    enable = 1'b1;
    step();
    check_eq("reen_e1_fs", frame_start, 0);
    check_eq("reen_e1_video", video_data, 21'h018000);
    step();
    check_eq("reen_e2_fs", frame_start, 1);
    check_eq("reen_e2_video", video_data, 21'h01C000);
    check_eq("reen_fc", frame_count, 4);
    step();
    check_eq("reen_e3_fs", frame_start, 0);

    // Asynchronous reset between clock edges
    repeat (300) step();
    #3;
    rst = 1'b0;
    #1;
    check_eq("arst_video", video_data, 21'h018000);
    check_eq("arst_fs", frame_start, 0);
    check_eq("arst_px", pixel_x, 0);
    check_eq("arst_py", pixel_y, 0);
    check_eq("arst_fc", frame_count, 0);

    guard = 0;
    while (!done_s && guard < 20000) begin
      @(posedge clk);
      guard++;
    end
    check_eq("wrap_done", done_s, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
